// File: rtl/oled_spi_ctrl_if.sv
// Byte-write port of the OLED SPI controller: byte, D/C flag and valid/ready
// handshake, plus the FIFO occupancy reported back to the writer.
interface oled_spi_ctrl_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    IN_DATA;
    logic          IN_DC;
    logic          IN_VALID;
    logic          IN_READY;
    logic [LW-1:0] FIFO_LEVEL;

    modport master (
        output IN_DATA, IN_DC, IN_VALID,
        input  IN_READY, FIFO_LEVEL
    );

    modport slave (
        input  IN_DATA, IN_DC, IN_VALID,
        output IN_READY, FIFO_LEVEL
    );
endinterface

// File: rtl/oled_spi_ctrl.sv
// Write-only SPI master (mode 0, MSB first) for SSD13xx OLED panels with
// power-on reset sequencing and a command/data byte FIFO.
module oled_spi_ctrl #(
    parameter int CLK_DIV         = 2,
    parameter int RES_LOW_CYCLES  = 1200,
    parameter int RES_WAIT_CYCLES = 3600,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic             CLK12,
    input  logic             RSTb,
    input  logic             ENABLE,
    input  logic             REINIT,
    oled_spi_ctrl_if.slave   bus,
    output logic             BUSY,
    output logic             OLED_RESb,
    output logic             OLED_CSb,
    output logic             OLED_DCb,
    output logic             OLED_SDIN,
    output logic             OLED_SCLK
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TMAX1 = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
    localparam int TMAX  = (TMAX1 > CLK_DIV) ? TMAX1 : CLK_DIV;
    localparam int CW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_RES_LOW, S_RES_WAIT, S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_END
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [2:0]     bit_reg, bit_next;
    logic [7:0]     sh_reg, sh_next;
    logic           resb_reg, resb_next;
    logic           csb_reg, csb_next;
    logic           dcb_reg, dcb_next;
    logic           sdin_reg, sdin_next;
    logic           sclk_reg, sclk_next;
    logic           reinit_reg, reinit_next, reinit_clr;

    logic [8:0]     mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]    level;
    logic           empty, full, push, pop;
    logic [8:0]     head;

    assign level = wr_ptr_reg - rd_ptr_reg;
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign push  = bus.IN_VALID && !full;
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    assign bus.IN_READY   = !full;
    assign bus.FIFO_LEVEL = level;

    always_ff @(posedge CLK12) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= {bus.IN_DC, bus.IN_DATA};
        end
    end

    always_ff @(posedge CLK12 or negedge RSTb) begin
        if (!RSTb) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            state_reg  <= S_RES_LOW;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            sh_reg     <= '0;
            resb_reg   <= 1'b0;
            csb_reg    <= 1'b1;
            dcb_reg    <= 1'b0;
            sdin_reg   <= 1'b0;
            sclk_reg   <= 1'b0;
            reinit_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            sh_reg     <= sh_next;
            resb_reg   <= resb_next;
            csb_reg    <= csb_next;
            dcb_reg    <= dcb_next;
            sdin_reg   <= sdin_next;
            sclk_reg   <= sclk_next;
            reinit_reg <= reinit_next;
        end
    end

    // A new REINIT request wins over clearing, so a request is never lost.
    assign reinit_next = REINIT || (reinit_reg && !reinit_clr);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        bit_next   = bit_reg;
        sh_next    = sh_reg;
        resb_next  = resb_reg;
        csb_next   = csb_reg;
        dcb_next   = dcb_reg;
        sdin_next  = sdin_reg;
        sclk_next  = sclk_reg;
        pop        = 1'b0;
        reinit_clr = 1'b0;
        case (state_reg)
            S_RES_LOW: begin
                resb_next = 1'b0;
                if (cnt_reg == CW'(RES_LOW_CYCLES - 1)) begin
                    cnt_next   = '0;
                    resb_next  = 1'b1;
                    state_next = S_RES_WAIT;
                end
            end
            S_RES_WAIT: begin
                if (cnt_reg == CW'(RES_WAIT_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                cnt_next  = '0;
                csb_next  = 1'b1;
                sclk_next = 1'b0;
                if (reinit_reg) begin
                    reinit_clr = 1'b1;
                    resb_next  = 1'b0;
                    state_next = S_RES_LOW;
                end else if (ENABLE && !empty) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                pop        = 1'b1;
                cnt_next   = '0;
                csb_next   = 1'b0;
                dcb_next   = head[8];
                sh_next    = head[7:0];
                sdin_next  = head[7];
                bit_next   = 3'd7;
                state_next = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (cnt_reg == CW'(CLK_DIV - 1)) begin
                    cnt_next   = '0;
                    sclk_next  = 1'b1;
                    state_next = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (cnt_reg == CW'(CLK_DIV - 1)) begin
                    cnt_next  = '0;
                    sclk_next = 1'b0;
                    if (bit_reg != 3'd0) begin
                        bit_next   = bit_reg - 1'b1;
                        sh_next    = {sh_reg[6:0], 1'b0};
                        sdin_next  = sh_reg[6];
                        state_next = S_SHIFT_LO;
                    end else if (ENABLE && !empty && !reinit_reg) begin
                        // Chain the next byte without releasing CSb.
                        pop        = 1'b1;
                        dcb_next   = head[8];
                        sh_next    = head[7:0];
                        sdin_next  = head[7];
                        bit_next   = 3'd7;
                        state_next = S_SHIFT_LO;
                    end else begin
                        state_next = S_END;
                    end
                end
            end
            S_END: begin
                // CSb rises CLK_DIV+1 cycles after the last SCLK falling edge.
                if (cnt_reg == CW'(CLK_DIV)) begin
                    cnt_next   = '0;
                    csb_next   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_RES_LOW;
            end
        endcase
    end

    assign BUSY      = (state_reg != S_IDLE) || !empty;
    assign OLED_RESb = resb_reg;
    assign OLED_CSb  = csb_reg;
    assign OLED_DCb  = dcb_reg;
    assign OLED_SDIN = sdin_reg;
    assign OLED_SCLK = sclk_reg;
endmodule

// File: tb/tb_oled_spi_ctrl.sv
// Randomised scoreboard bench: accepted bytes are queued in order, and a pin
// monitor decodes the SPI stream and checks bytes, D/C and CSb timing.
module tb_oled_spi_ctrl;
    localparam int D     = 2;
    localparam int RL    = 10;
    localparam int RW    = 20;
    localparam int DEPTH = 16;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic enable = 1'b0;
    logic reinit = 1'b0;
    logic busy, resb, csb, dcb, sdin, sclk;

    oled_spi_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

    oled_spi_ctrl #(
        .CLK_DIV(D), .RES_LOW_CYCLES(RL), .RES_WAIT_CYCLES(RW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK12(clk), .RSTb(rst_n), .ENABLE(enable), .REINIT(reinit), .bus(bus),
        .BUSY(busy), .OLED_RESb(resb), .OLED_CSb(csb), .OLED_DCb(dcb),
        .OLED_SDIN(sdin), .OLED_SCLK(sclk)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int first_fall = -1;
    logic [8:0] sb [$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_resb"}, resb, 0);
        check({tag, "_csb"}, csb, 1);
        check({tag, "_dcb"}, dcb, 0);
        check({tag, "_sdin"}, sdin, 0);
        check({tag, "_sclk"}, sclk, 0);
        check({tag, "_ready"}, bus.IN_READY, 1);
        check({tag, "_level"}, bus.FIFO_LEVEL, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] d, input logic dc);
        int n = 0;
        bus.IN_DATA  = d;
        bus.IN_DC    = dc;
        bus.IN_VALID = 1'b1;
        while (!bus.IN_READY && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.IN_READY) check("push_timeout", 0, 1);
        else sb.push_back({dc, d});
        @(negedge clk);
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, (!busy && sb.size() == 0), 1);
    endtask

    task automatic wait_csb(input string name, input logic v, input int budget);
        int n = 0;
        while (csb !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_csb_wait"}, csb, v);
    endtask

    // Pin monitor: decodes bytes on SCLK rising edges and checks them against the scoreboard.
    initial begin
        logic p_cs, p_sclk, p_sdin, p_dc, in_run, dc0;
        logic [7:0] shv;
        logic [8:0] e;
        int last_chg, bitcnt, nb, run;
        p_cs = 1; p_sclk = 0; p_sdin = 0; p_dc = 0; in_run = 0; dc0 = 0; shv = 0;
        last_chg = 0; bitcnt = 0; nb = 0; run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bitcnt = 0; nb = 0; run = 0; in_run = 0;
            end else begin
                if ((sdin !== p_sdin) || (dcb !== p_dc)) begin
                    check("data_change_while_sclk_low", sclk, 0);
                    last_chg = cyc;
                end
                if (p_cs && !csb) begin
                    in_run = 1; run = 0; nb = 0;
                    if (first_fall < 0) first_fall = cyc;
                end
                if (!csb) run++;
                if (!p_sclk && sclk) begin
                    check("csb_low_on_sclk_rise", csb, 0);
                    check("setup_ge_clk_div", (cyc - last_chg) >= D, 1);
                    if (bitcnt == 0) dc0 = dcb;
                    shv = {shv[6:0], sdin};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        bitcnt = 0;
                        nb++;
                        if (sb.size() == 0) begin
                            check("unexpected_byte", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            check("byte_data", shv, e[7:0]);
                            check("byte_dc", dc0, e[8]);
                            $display("[TB] byte 0x%02h dc=%0d cycle %0d", shv, dc0, cyc);
                        end
                    end
                end
                if (!p_cs && csb && in_run) begin
                    in_run = 0;
                    check("byte_complete_at_cs_rise", bitcnt, 0);
                    check("csb_low_cycles", run, 1 + 16 * D * nb + D);
                end
            end
            p_cs = csb; p_sclk = sclk; p_sdin = sdin; p_dc = dcb;
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, sent, n;
        logic [8:0] burst [17];
        bus.IN_VALID = 0; bus.IN_DATA = 0; bus.IN_DC = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");

        // Reset sequence with 17 pushes offered while the panel is held in reset.
        for (int i = 0; i < 17; i++) burst[i] = 9'($urandom_range(0, 511));
        enable = 1'b1;
        first_fall = -1;
        rst_n = 1'b1;
        rel = cyc;
        sent = 0;
        for (int k = 0; k <= RL + RW; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check("resb_sequence", resb, (k >= RL) ? 1 : 0);
                check("busy_in_reset", busy, 1);
            end
            if (k == DEPTH) begin
                check("full_ready_low", bus.IN_READY, 0);
                check("full_level", bus.FIFO_LEVEL, DEPTH);
            end
            if (sent < 17) begin
                bus.IN_DATA = burst[sent][7:0];
                bus.IN_DC = burst[sent][8];
                bus.IN_VALID = 1'b1;
                if (bus.IN_READY) begin
                    sb.push_back(burst[sent]);
                    sent++;
                end
            end else begin
                bus.IN_VALID = 1'b0;
            end
        end
        n = 0;
        while (sent < 17 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.IN_READY) begin
                sb.push_back(burst[sent]);
                sent++;
            end
        end
        check("held_push_accepted", sent, 17);
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        wait_idle("full_fifo", 17 * 16 * D + 200);
        check("first_csb_fall_ge", (first_fall - rel) >= RL + RW + 1, 1);

        // Single byte 0xA5 into an idle, empty FIFO: exact latency to CSb fall.
        push(8'hA5, 1'b0);
        check("lat_edge0_csb", csb, 1);
        check("lat_edge0_level", bus.FIFO_LEVEL, 1);
        @(negedge clk);
        check("lat_edge1_csb", csb, 1);
        @(negedge clk);
        check("lat_edge2_csb", csb, 0);
        wait_idle("single", 200);

        // Back-to-back pair followed by random bursts.
        push(8'hAF, 1'b0);
        push(8'h3C, 1'b1);
        wait_idle("b2b", 300);
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) push(8'($urandom), 1'($urandom));
            wait_idle("burst", 400);
        end

        // ENABLE dropped during byte 1 of 3.
        for (int i = 0; i < 3; i++) push(8'($urandom), 1'($urandom));
        wait_csb("en", 1'b0, 50);
        repeat (1 + 3 * 2 * D) @(negedge clk);
        enable = 1'b0;
        wait_csb("en_stop", 1'b1, 100);
        check("en_low_level", bus.FIFO_LEVEL, 2);
        repeat (10) @(negedge clk);
        check("en_low_csb_idle", csb, 1);
        check("en_low_level_hold", bus.FIFO_LEVEL, 2);
        check("en_low_busy", busy, 1);
        enable = 1'b1;
        wait_idle("en_resume", 300);

        // REINIT mid-byte: byte finishes, reset pulse, queued byte after the wait.
        push(8'($urandom), 1'($urandom));
        push(8'($urandom), 1'($urandom));
        wait_csb("ri", 1'b0, 50);
        repeat (5) @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        n = 0;
        while (resb && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ri_resb_fell", resb, 0);
        check("ri_csb_high", csb, 1);
        check("ri_level_kept", bus.FIFO_LEVEL, 1);
        n = 0;
        while (!resb && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ri_resb_low_cycles", n, RL);
        n = 0;
        while (csb && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ri_wait_before_byte", n >= RW + 1, 1);
        wait_idle("ri", 300);

        // Asynchronous reset mid-byte.
        for (int i = 0; i < 3; i++) push(8'($urandom), 1'($urandom));
        wait_csb("rst", 1'b0, 50);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push(8'h5A, 1'b1);
        wait_idle("post_rst", RL + RW + 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
